// File: rtl/alu_bist_ctrl.sv
// alu_bist_ctrl: on-chip self-test sequencer for the datapath ALU.
//   Fetches {opcode, operand_0, operand_1, expected} vectors from a vector memory,
//   drives them onto the ALU, waits ALU_LATENCY cycles, compares the result
//   bit-for-bit with the golden value and tallies pass / fail / skip counts.
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   start / busy / done / pass run handshake and verdict (pass valid while done)
//   vec_rd_en, vec_addr        one-cycle read request and vector index to memory
//   vec_rd_valid, vec_*        returned vector fields (accepted only while fetching)
//   alu_opcode, alu_operand_*  registered ALU stimulus, held between vectors
//   alu_result                 ALU result sampled in the compare state
//   pass/fail/skip_count       run tallies (ADDR_WIDTH+1 bits, cannot wrap)
//   first_fail_idx             index of the first mismatching vector
module alu_bist_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int NUM_VECTORS = 1000,
  parameter int ALU_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  vec_rd_en,
  output logic [ADDR_WIDTH-1:0] vec_addr,
  input  logic                  vec_rd_valid,
  input  logic [3:0]            vec_opcode,
  input  logic [DATA_WIDTH-1:0] vec_operand_0,
  input  logic [DATA_WIDTH-1:0] vec_operand_1,
  input  logic [DATA_WIDTH-1:0] vec_expected,
  output logic [3:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_operand_0,
  output logic [DATA_WIDTH-1:0] alu_operand_1,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic [ADDR_WIDTH:0]   pass_count,
  output logic [ADDR_WIDTH:0]   fail_count,
  output logic [ADDR_WIDTH:0]   skip_count,
  output logic [ADDR_WIDTH-1:0] first_fail_idx
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int LW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = (NUM_VECTORS > 0) ? ADDR_WIDTH'(NUM_VECTORS - 1) : {ADDR_WIDTH{1'b0}};
  localparam logic [LW-1:0]         LAST_WAIT = LW'(ALU_LATENCY - 1);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = ADDR_WIDTH'(1);
  localparam logic [LW-1:0]         WAIT_ONE  = LW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRIVE = 3'd2,
    S_WAIT  = 3'd3,
    S_CHECK = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  // Opcodes the ALU implements; anything else is skipped without reaching the ALU.
  function automatic logic op_supported(input logic [3:0] op);
    logic ok;
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9: ok = 1'b1;
      default:                                               ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
  logic [LW-1:0]          wait_cnt_q, wait_cnt_d;
  logic                   rd_en_q, rd_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [3:0]             cap_op_q, cap_op_d;
  logic [DATA_WIDTH-1:0]  cap_a_q, cap_a_d;
  logic [DATA_WIDTH-1:0]  cap_b_q, cap_b_d;
  logic [DATA_WIDTH-1:0]  cap_exp_q, cap_exp_d;
  logic [3:0]             alu_op_q, alu_op_d;
  logic [DATA_WIDTH-1:0]  alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0]  alu_b_q, alu_b_d;
  logic [CW-1:0]          pass_cnt_q, pass_cnt_d;
  logic [CW-1:0]          fail_cnt_q, fail_cnt_d;
  logic [CW-1:0]          skip_cnt_q, skip_cnt_d;
  logic [ADDR_WIDTH-1:0]  first_fail_q, first_fail_d;

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wait_cnt_d   = wait_cnt_q;
    rd_en_d      = 1'b0;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    cap_op_d     = cap_op_q;
    cap_a_d      = cap_a_q;
    cap_b_d      = cap_b_q;
    cap_exp_d    = cap_exp_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    pass_cnt_d   = pass_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    skip_cnt_d   = skip_cnt_q;
    first_fail_d = first_fail_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pass_cnt_d   = {CW{1'b0}};
          fail_cnt_d   = {CW{1'b0}};
          skip_cnt_d   = {CW{1'b0}};
          first_fail_d = {ADDR_WIDTH{1'b0}};
          idx_d        = {ADDR_WIDTH{1'b0}};
          if (NUM_VECTORS == 0) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = S_FETCH;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            rd_en_d = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: begin
        // Data cannot legally return in the request cycle itself, so a valid
        // seen while rd_en is still high is stale and ignored.
        if (vec_rd_valid && !rd_en_q) begin
          cap_op_d  = vec_opcode;
          cap_a_d   = vec_operand_0;
          cap_b_d   = vec_operand_1;
          cap_exp_d = vec_expected;
          if (op_supported(vec_opcode)) begin
            state_d = S_DRIVE;
          end else begin
            skip_cnt_d = skip_cnt_q + CNT_ONE;
            state_d    = S_NEXT;
          end
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DRIVE: begin
        alu_op_d   = cap_op_q;
        alu_a_d    = cap_a_q;
        alu_b_d    = cap_b_q;
        wait_cnt_d = {LW{1'b0}};
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == LAST_WAIT) begin
          state_d = S_CHECK;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      S_CHECK: begin
        // Case equality so an undriven / X result bit is a mismatch.
        if (alu_result === cap_exp_q) begin
          pass_cnt_d = pass_cnt_q + CNT_ONE;
        end else begin
          fail_cnt_d = fail_cnt_q + CNT_ONE;
          if (fail_cnt_q == {CW{1'b0}}) begin
            first_fail_d = idx_q;
          end else begin
            first_fail_d = first_fail_q;
          end
        end
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_cnt_q == {CW{1'b0}});
        end else begin
          idx_d   = idx_q + IDX_ONE;
          rd_en_d = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= {ADDR_WIDTH{1'b0}};
      wait_cnt_q   <= {LW{1'b0}};
      rd_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      cap_op_q     <= 4'd0;
      cap_a_q      <= {DATA_WIDTH{1'b0}};
      cap_b_q      <= {DATA_WIDTH{1'b0}};
      cap_exp_q    <= {DATA_WIDTH{1'b0}};
      alu_op_q     <= 4'd0;
      alu_a_q      <= {DATA_WIDTH{1'b0}};
      alu_b_q      <= {DATA_WIDTH{1'b0}};
      pass_cnt_q   <= {CW{1'b0}};
      fail_cnt_q   <= {CW{1'b0}};
      skip_cnt_q   <= {CW{1'b0}};
      first_fail_q <= {ADDR_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wait_cnt_q   <= wait_cnt_d;
      rd_en_q      <= rd_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      cap_op_q     <= cap_op_d;
      cap_a_q      <= cap_a_d;
      cap_b_q      <= cap_b_d;
      cap_exp_q    <= cap_exp_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      skip_cnt_q   <= skip_cnt_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign vec_rd_en      = rd_en_q;
  assign vec_addr       = idx_q;
  assign alu_opcode     = alu_op_q;
  assign alu_operand_0  = alu_a_q;
  assign alu_operand_1  = alu_b_q;
  assign pass_count     = pass_cnt_q;
  assign fail_count     = fail_cnt_q;
  assign skip_count     = skip_cnt_q;
  assign first_fail_idx = first_fail_q;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Self-checking bench for alu_bist_ctrl: vector memory with variable read
// latency, pipelined ALU model and a run-level reference model.
module tb_alu_bist_ctrl;
  localparam int DW  = 32;
  localparam int AW  = 3;
  localparam int NV  = 6;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass, vec_rd_en;
  logic [AW-1:0] vec_addr;
  logic          vec_rd_valid = 1'b0;
  logic [3:0]    vec_opcode = 4'd0;
  logic [DW-1:0] vec_operand_0 = '0, vec_operand_1 = '0, vec_expected = '0;
  logic [3:0]    alu_opcode;
  logic [DW-1:0] alu_operand_0, alu_operand_1;
  logic [DW-1:0] alu_result = '0;
  logic [AW:0]   pass_count, fail_count, skip_count;
  logic [AW-1:0] first_fail_idx;

  // second instance with an empty vector set
  logic          start0 = 1'b0;
  logic          busy0, done0, pass0, rd_en0;
  logic [AW-1:0] addr0, ffi0;
  logic [3:0]    aop0;
  logic [DW-1:0] aa0, ab0;
  logic [AW:0]   pc0, fc0, sc0;
  logic          zero_bit = 1'b0;
  logic [3:0]    zero_op = 4'd0;
  logic [DW-1:0] zero_w = '0;

  always #5 clk = ~clk;

  alu_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_VECTORS(NV), .ALU_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .vec_rd_en(vec_rd_en), .vec_addr(vec_addr), .vec_rd_valid(vec_rd_valid),
    .vec_opcode(vec_opcode), .vec_operand_0(vec_operand_0), .vec_operand_1(vec_operand_1),
    .vec_expected(vec_expected), .alu_opcode(alu_opcode), .alu_operand_0(alu_operand_0),
    .alu_operand_1(alu_operand_1), .alu_result(alu_result), .pass_count(pass_count),
    .fail_count(fail_count), .skip_count(skip_count), .first_fail_idx(first_fail_idx));

  alu_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_VECTORS(0), .ALU_LATENCY(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
    .vec_rd_en(rd_en0), .vec_addr(addr0), .vec_rd_valid(zero_bit),
    .vec_opcode(zero_op), .vec_operand_0(zero_w), .vec_operand_1(zero_w),
    .vec_expected(zero_w), .alu_opcode(aop0), .alu_operand_0(aa0),
    .alu_operand_1(ab0), .alu_result(zero_w), .pass_count(pc0),
    .fail_count(fc0), .skip_count(sc0), .first_fail_idx(ffi0));

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural ALU
  function automatic logic [DW-1:0] alu_fn(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd6: r = a << b[4:0];
      4'd7: r = a >> b[4:0];
      4'd8: r = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd9: r = a * b;
      default: r = 32'hDEAD_BEEF;
    endcase
    return r;
  endfunction

  function automatic bit is_supported(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9};
  endfunction

  // Vector memory contents
  logic [3:0]    m_op [NV];
  logic [DW-1:0] m_a  [NV];
  logic [DW-1:0] m_b  [NV];
  logic [DW-1:0] m_e  [NV];

  int fixed_lat  = 0;
  int bad_alu_op = 0;
  int rd_viol    = 0;
  int addr_log[$];

  // Memory responder + pipelined ALU, updated 1 time unit after each rising edge.
  initial begin
    logic          pending;
    int            cnt;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] pipe [0:LAT];
    pending = 1'b0;
    cnt = 0;
    req_addr = '0;
    for (int j = 0; j <= LAT; j++) pipe[j] = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int j = LAT; j > 0; j--) pipe[j] = pipe[j-1];
      pipe[0] = alu_fn(alu_opcode, alu_operand_0, alu_operand_1);
      alu_result = pipe[LAT];
      if (!is_supported(alu_opcode)) bad_alu_op++;
      vec_rd_valid  = 1'b0;
      vec_opcode    = 4'($urandom_range(0, 15));
      vec_operand_0 = $urandom;
      vec_operand_1 = $urandom;
      vec_expected  = $urandom;
      if (!rst_n) begin
        pending = 1'b0;
      end else if (vec_rd_en) begin
        if (pending) rd_viol++;
        pending  = 1'b1;
        req_addr = vec_addr;
        cnt      = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
        addr_log.push_back(int'(vec_addr));
      end else if (pending) begin
        if (vec_addr != req_addr) rd_viol++;
        cnt--;
        if (cnt == 0) begin
          pending      = 1'b0;
          vec_rd_valid = 1'b1;
          if (int'(req_addr) < NV) begin
            vec_opcode    = m_op[req_addr];
            vec_operand_0 = m_a[req_addr];
            vec_operand_1 = m_b[req_addr];
            vec_expected  = m_e[req_addr];
          end
        end
      end else if ($urandom_range(0, 5) == 0) begin
        vec_rd_valid = 1'b1;   // stray valid with garbage data, must be ignored
      end
    end
  end

  // Run-level reference: what the tallies must be for the loaded vector set.
  task automatic ref_model(output int p, output int f, output int s, output int ff);
    p = 0; f = 0; s = 0; ff = 0;
    for (int i = 0; i < NV; i++) begin
      if (!is_supported(m_op[i])) s++;
      else if (alu_fn(m_op[i], m_a[i], m_b[i]) == m_e[i]) p++;
      else begin
        if (f == 0) ff = i;
        f++;
      end
    end
  endtask

  task automatic load_add();
    for (int i = 0; i < NV; i++) begin
      m_op[i] = 4'd0;
      m_a[i]  = {8'(i + 1), 24'($urandom)};
      m_b[i]  = $urandom;
      m_e[i]  = alu_fn(m_op[i], m_a[i], m_b[i]);
    end
  endtask

  task automatic load_random();
    logic [3:0] ops [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9};
    for (int i = 0; i < NV; i++) begin
      m_op[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 8)];
      m_a[i]  = {8'(i + 1), 24'($urandom)};
      m_b[i]  = $urandom;
      m_e[i]  = alu_fn(m_op[i], m_a[i], m_b[i]);
      if ($urandom_range(0, 4) == 0) m_e[i] = m_e[i] ^ (32'd1 << $urandom_range(0, 31));
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #2; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
  endtask

  task automatic check_zero(input string name);
    check_val({name, "_busy"}, busy, 0);
    check_val({name, "_done"}, done, 0);
    check_val({name, "_pass"}, pass, 0);
    check_val({name, "_rd_en"}, vec_rd_en, 0);
    check_val({name, "_addr"}, vec_addr, 0);
    check_val({name, "_alu"}, {alu_opcode, alu_operand_0, alu_operand_1}, 0);
    check_val({name, "_cnts"}, {pass_count, fail_count, skip_count, first_fail_idx}, 0);
  endtask

  task automatic run_and_check(input string name, input bit mid_start);
    int p, f, s, ff, cyc, ord_err;
    addr_log.delete();
    rd_viol = 0;
    bad_alu_op = 0;
    pulse_start();
    check_val({name, "_busy_after_start"}, busy, 1);
    check_val({name, "_done_after_start"}, done, 0);
    if (mid_start) begin
      repeat (5) @(posedge clk);
      #2; start = 1'b1;
      @(posedge clk); #2; start = 1'b0;
      check_val({name, "_busy_ignore_start"}, busy, 1);
    end
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(posedge clk); #2;
      cyc++;
    end
    check_val({name, "_done"}, done, 1);
    ref_model(p, f, s, ff);
    check_val({name, "_busy_end"}, busy, 0);
    check_val({name, "_pass_cnt"}, pass_count, p);
    check_val({name, "_fail_cnt"}, fail_count, f);
    check_val({name, "_skip_cnt"}, skip_count, s);
    check_val({name, "_pass"}, pass, (f == 0));
    if (f != 0) check_val({name, "_first_fail"}, first_fail_idx, ff);
    check_val({name, "_rd_count"}, addr_log.size(), NV);
    ord_err = 0;
    foreach (addr_log[i]) if (addr_log[i] != i) ord_err++;
    check_val({name, "_rd_order"}, ord_err, 0);
    check_val({name, "_rd_protocol"}, rd_viol, 0);
    check_val({name, "_alu_bad_op"}, bad_alu_op, 0);
    repeat (3) @(posedge clk);
    #2;
    check_val({name, "_done_held"}, {done, pass}, {1'b1, (f == 0)});
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset");
    check_val("reset_dut0_done", done0, 0);
    rst_n = 1'b1;

    // all-ADD vectors, ideal memory
    load_add();
    run_and_check("add", 1'b0);

    // vector 2 corrupted: SUB 5-3 with expected 3
    load_add();
    m_op[2] = 4'd1; m_a[2] = 32'd5; m_b[2] = 32'd3; m_e[2] = 32'd3;
    run_and_check("corrupt", 1'b0);
    check_val("corrupt_first_idx", first_fail_idx, 2);

    // unsupported opcodes 5 and F
    load_add();
    m_op[1] = 4'd5; m_op[4] = 4'hF;
    run_and_check("skip", 1'b0);
    check_val("skip_count2", skip_count, 2);

    // slow memory
    fixed_lat = 5;
    load_add();
    run_and_check("slow_mem", 1'b0);
    fixed_lat = 0;

    // start pulsed while busy
    load_random();
    run_and_check("busy_start", 1'b1);

    // reset while waiting on vector 3's ALU result
    load_add();
    pulse_start();
    cyc = 0;
    while (alu_operand_0 != m_a[3] && cyc < 500) begin
      @(posedge clk); #2;
      cyc++;
    end
    check_val("midrst_reach_v3", (alu_operand_0 == m_a[3]), 1);
    #3; rst_n = 1'b0;
    #1;
    check_zero("midrst");
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    run_and_check("after_rst", 1'b0);

    // randomized vector sets
    for (int k = 0; k < 8; k++) begin
      load_random();
      fixed_lat = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
      run_and_check($sformatf("rand%0d", k), 1'b0);
    end
    fixed_lat = 0;

    // empty vector set: done one cycle after start
    @(posedge clk); #2;
    check_val("empty_done_before", done0, 0);
    start0 = 1'b1;
    @(posedge clk); #2;
    start0 = 1'b0;
    check_val("empty_done", {done0, pass0, busy0}, 3'b110);
    check_val("empty_cnts", {pc0, fc0, sc0, rd_en0}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
